// File: rtl/wb_rr_arb4.sv
// Four-way round-robin arbiter with a one-entry registered output.
// It drives the select of the downstream 4:1 data mux and holds one transfer.
module wb_rr_arb4 #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         in_valid,
    input  logic [4*WIDTH-1:0] in_data,
    output logic [3:0]         in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [1:0]         out_src,
    input  logic               out_ready
);

    logic [1:0]       ptr_p1;
    logic             vld_p1;
    logic [WIDTH-1:0] data_p1;
    logic [1:0]       src_p1;

    logic             load_en;
    logic             gnt_vld;
    logic [1:0]       gnt;
    logic             xfer;
    logic [WIDTH-1:0] mux_data;

    // Returns {found, index} of the first set request at or after base, wrapping.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] base);
        logic [2:0] r;
        logic [1:0] idx;
        r = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = base + 2'(k);
            if (req[idx]) begin
                r = {1'b1, idx};
            end
        end
        return r;
    endfunction

    always_comb begin
        load_en        = !vld_p1 || out_ready;
        {gnt_vld, gnt} = rr_pick(in_valid, ptr_p1);
        xfer           = !reset && load_en && gnt_vld;
    end

    always_comb begin
        in_ready = 4'b0000;
        if (xfer) begin
            in_ready[gnt] = 1'b1;
        end
    end

    always_comb begin
        case (gnt)
            2'd0:    mux_data = in_data[0*WIDTH +: WIDTH];
            2'd1:    mux_data = in_data[1*WIDTH +: WIDTH];
            2'd2:    mux_data = in_data[2*WIDTH +: WIDTH];
            default: mux_data = in_data[3*WIDTH +: WIDTH];
        endcase
    end

    // Stage p1: output register and priority pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            src_p1  <= 2'd0;
            ptr_p1  <= 2'd0;
        end else if (load_en) begin
            if (xfer) begin
                vld_p1  <= 1'b1;
                data_p1 <= mux_data;
                src_p1  <= gnt;
                ptr_p1  <= gnt + 2'd1;
            end else begin
                vld_p1  <= 1'b0;
            end
        end
    end

    assign out_valid = vld_p1;
    assign out_data  = data_p1;
    assign out_src   = src_p1;

endmodule
